instruction_fetch: RTL



---
 rtl/instruction_fetch.sv | 100 ++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, selects BIOS or user word, registers it for decode.
// Define FETCH_BOUNDS_CHECK_EN to halt on out-of-range BIOS fetches (adds bounds_fault).
module instruction_fetch #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BIOS_WORDS  = 186,
  parameter int unsigned HALT_OPCODE = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              boot_done,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] bios_instruction,
  input  logic [DATA_W-1:0] user_instruction,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid,
  output logic              halted,
  output logic              src_user
`ifdef FETCH_BOUNDS_CHECK_EN
  ,
  output logic              bounds_fault
`endif
);

  localparam logic [1:0] S_INIT   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] sel_word;
  logic              is_halt;

  assign address  = pc;
  assign sel_word = src_user ? user_instruction : bios_instruction;
  assign is_halt  = (sel_word[DATA_W-1 -: 6] == 6'(HALT_OPCODE));

`ifdef FETCH_BOUNDS_CHECK_EN
  logic bios_oob;
  assign bios_oob = !src_user && (32'(pc) >= 32'(BIOS_WORDS));
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_INIT;
      pc          <= '0;
      src_user    <= 1'b0;
      instr_out   <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
      bounds_fault <= 1'b0;
`endif
    end else begin
      case (state)
        S_INIT: state <= S_FETCH;
        S_FETCH: begin
          if (branch_taken) begin
            pc          <= branch_target;
            instr_valid <= 1'b0;
          end else if (boot_done && !src_user) begin
            // The BIOS word at the current pc is dropped; user fetch restarts at 0.
            src_user    <= 1'b1;
            pc          <= '0;
            instr_valid <= 1'b0;
          end else if (!stall) begin
`ifdef FETCH_BOUNDS_CHECK_EN
            if (bios_oob) begin
              instr_valid  <= 1'b0;
              state        <= S_HALTED;
              halted       <= 1'b1;
              bounds_fault <= 1'b1;
            end else
`endif
            begin
              instr_out   <= sel_word;
              pc_out      <= pc;
              instr_valid <= 1'b1;
              // The halt word itself is issued; pc stays on it.
              if (is_halt) begin
                state  <= S_HALTED;
                halted <= 1'b1;
              end else begin
                pc <= pc + 1'b1;
              end
            end
          end
        end
        S_HALTED: instr_valid <= 1'b0;
        default:  state <= S_INIT;
      endcase
    end
  end

endmodule
